// File: rtl/aes_pkg.sv
// Shared AES definitions: round-constant parameters, key-schedule FSM states and
// the GF(2^8) doubling helper also used by MixColumns.
package aes_pkg;

    localparam logic [7:0] AES_RCON_INIT = 8'h01;
    localparam logic [7:0] AES_RCON_POLY = 8'h1b;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_state_e;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box; the table is stored with entry 0 in the top byte.
module sbox (
    input  logic [7:0] data,
    output logic [7:0] dout
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n lives at bit offset 8*(255-n), and 255-n is simply ~n.
    assign dout = SBOX_TABLE[{~data, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 iterative key schedule: emits round keys 0..NUM_ROUNDS over a
// valid/ready stream, one key per accepted handshake.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    aes_state_e   state_q, state_d;
    logic [127:0] rkOut_q, rkOut_d;
    logic [3:0]   rkIdx_q, rkIdx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         rkValid_q, rkValid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rotWord, subWord, tWord;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] nextKey;

    assign {w0, w1, w2, w3} = rkOut_q;
    assign rotWord = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        sbox u_sbox (
            .data (rotWord[8*b +: 8]),
            .dout (subWord[8*b +: 8])
        );
    end

    assign tWord   = subWord ^ {rcon_q, 24'h0};
    assign n0      = w0 ^ tWord;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign nextKey = {n0, n1, n2, n3};

    always_comb begin
        state_d   = state_q;
        rkOut_d   = rkOut_q;
        rkIdx_d   = rkIdx_q;
        rcon_d    = rcon_q;
        rkValid_d = rkValid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rkOut_d   = key_in;
                    rkIdx_d   = 4'd0;
                    rcon_d    = AES_RCON_INIT;
                    rkValid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here; a run cannot be restarted.
                if (rk_ready) begin
                    if (rkIdx_q == LAST_IDX) begin
                        rkValid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        rkOut_d = nextKey;
                        rkIdx_d = rkIdx_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rkOut_q   <= '0;
            rkIdx_q   <= '0;
            rcon_q    <= AES_RCON_INIT;
            rkValid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rkOut_q   <= rkOut_d;
            rkIdx_q   <= rkIdx_d;
            rcon_q    <= rcon_d;
            rkValid_q <= rkValid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rk_valid = rkValid_q;
    assign rk_out   = rkOut_q;
    assign rk_idx   = rkIdx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
